// File: rtl/counter_run_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : counter_run_ctrl_if
// Brief    : Requester-side bundle for counter_run_ctrl (requests, targets,
//            grants, completion, status).
// Revision : 1.0 - initial release
// ============================================================================
interface counter_run_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] tgt0;
  logic [WIDTH-1:0] tgt1;
  logic             gnt0;
  logic             gnt1;
  logic             done0;
  logic             done1;
  logic [WIDTH-1:0] last_cnt;
  logic             busy;
  logic             wdog_err;

  modport master (
    output req0, req1, tgt0, tgt1,
    input  gnt0, gnt1, done0, done1, last_cnt, busy, wdog_err
  );

  modport slave (
    input  req0, req1, tgt0, tgt1,
    output gnt0, gnt1, done0, done1, last_cnt, busy, wdog_err
  );
endinterface
`default_nettype wire

// File: rtl/counter_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : counter_run_ctrl
// Brief    : Round-robin run controller for the dual-edge counter: grant,
//            clear, enable to terminal count, report. Optional watchdog
//            enabled by defining CTRL_WDOG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module counter_run_ctrl #(
  parameter int WIDTH    = 4,
  parameter int WDOG_CYC = 16
) (
  input  wire logic             clk,
  input  wire logic             rst,
  counter_run_ctrl_if.slave     rq,
  input  wire logic [WIDTH-1:0] cnt_val,
  output logic                  cnt_clr,
  output logic                  cnt_en
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Counter steps up to 2 per clk, so the all-ones value could be skipped over.
  localparam logic [WIDTH-1:0] c_tgt_max = {{(WIDTH-1){1'b1}}, 1'b0};

  state_t           r_state, w_state_nxt;
  logic             r_own, w_own_nxt;
  logic             r_last, w_last_nxt;
  logic [WIDTH-1:0] r_tgt_q, w_tgt_nxt;
  logic [WIDTH-1:0] r_last_cnt, w_last_cnt_nxt;
  logic             r_gnt0, r_gnt1, r_done0, r_done1, r_cnt_clr, r_busy, r_wdog_err;
  logic             w_wdog_nxt;
  logic             w_own_req, w_hit, w_sel, w_wdog_to;
  logic [WIDTH-1:0] w_tgt_raw;

  assign w_own_req = r_own ? rq.req1 : rq.req0;
  assign w_hit     = (cnt_val >= r_tgt_q);
  assign w_sel     = (rq.req0 & rq.req1) ? ~r_last : rq.req1;
  assign w_tgt_raw = w_sel ? rq.tgt1 : rq.tgt0;

`ifdef CTRL_WDOG_EN
  localparam int WDW = $clog2(WDOG_CYC + 1);
  logic [WDW-1:0] r_wdog_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wdog_cnt <= '0;
    end else if (r_state != ST_RUN) begin
      r_wdog_cnt <= '0;
    end else begin
      r_wdog_cnt <= r_wdog_cnt + 1'b1;
    end
  end

  assign w_wdog_to = (r_state == ST_RUN) && (r_wdog_cnt == WDW'(WDOG_CYC - 1));
`else
  // Watchdog compiled out; the term is constant false for any legal limit.
  assign w_wdog_to = (WDOG_CYC < 0);
`endif

  always_comb begin
    w_state_nxt    = r_state;
    w_own_nxt      = r_own;
    w_last_nxt     = r_last;
    w_tgt_nxt      = r_tgt_q;
    w_last_cnt_nxt = r_last_cnt;
    w_wdog_nxt     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (rq.req0 | rq.req1) begin
          w_state_nxt = ST_CLEAR;
          w_own_nxt   = w_sel;
          w_last_nxt  = w_sel;
          w_tgt_nxt   = (w_tgt_raw > c_tgt_max) ? c_tgt_max : w_tgt_raw;
        end
      end
      ST_CLEAR: w_state_nxt = w_own_req ? ST_RUN : ST_IDLE;
      ST_RUN: begin
        if (!w_own_req) begin
          w_state_nxt = ST_IDLE;
        end else if (w_hit) begin
          w_state_nxt    = ST_DONE;
          w_last_cnt_nxt = cnt_val;
        end else if (w_wdog_to) begin
          w_state_nxt = ST_IDLE;
          w_wdog_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_own      <= 1'b0;
      r_last     <= 1'b1;
      r_tgt_q    <= '0;
      r_last_cnt <= '0;
      r_gnt0     <= 1'b0;
      r_gnt1     <= 1'b0;
      r_done0    <= 1'b0;
      r_done1    <= 1'b0;
      r_cnt_clr  <= 1'b0;
      r_busy     <= 1'b0;
      r_wdog_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_own      <= w_own_nxt;
      r_last     <= w_last_nxt;
      r_tgt_q    <= w_tgt_nxt;
      r_last_cnt <= w_last_cnt_nxt;
      r_gnt0     <= (w_state_nxt != ST_IDLE) && !w_own_nxt;
      r_gnt1     <= (w_state_nxt != ST_IDLE) &&  w_own_nxt;
      r_done0    <= (w_state_nxt == ST_DONE) && !w_own_nxt;
      r_done1    <= (w_state_nxt == ST_DONE) &&  w_own_nxt;
      r_cnt_clr  <= (w_state_nxt == ST_CLEAR);
      r_busy     <= (w_state_nxt != ST_IDLE);
      r_wdog_err <= w_wdog_nxt;
    end
  end

  assign cnt_en      = (r_state == ST_RUN) && !w_hit;
  assign cnt_clr     = r_cnt_clr;
  assign rq.gnt0     = r_gnt0;
  assign rq.gnt1     = r_gnt1;
  assign rq.done0    = r_done0;
  assign rq.done1    = r_done1;
  assign rq.last_cnt = r_last_cnt;
  assign rq.busy     = r_busy;
  assign rq.wdog_err = r_wdog_err;

endmodule
`default_nettype wire

// File: tb/tb_counter_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_run_ctrl
// Brief    : Directed + randomized bench for counter_run_ctrl with a counter
//            model and a transaction-level reference (CTRL_WDOG_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
module tb_counter_run_ctrl;

  localparam int WIDTH    = 4;
  localparam int WDOG_CYC = 16;
  localparam int TGT_MAX  = (1 << WIDTH) - 2;
`ifdef CTRL_WDOG_EN
  localparam bit WDOG_ON = 1'b1;
`else
  localparam bit WDOG_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] cnt_val;
  logic             cnt_clr, cnt_en;
  int               step = 2;
  bit               stuck = 1'b0;
  bit               rnd_step = 1'b0;
  int               n_total = 0;
  int               n_bad = 0;

  counter_run_ctrl_if #(.WIDTH(WIDTH)) bus ();

  counter_run_ctrl #(.WIDTH(WIDTH), .WDOG_CYC(WDOG_CYC)) dut (
    .clk     (clk),
    .rst     (rst),
    .rq      (bus),
    .cnt_val (cnt_val),
    .cnt_clr (cnt_clr),
    .cnt_en  (cnt_en)
  );

  always #5 clk = ~clk;

  // Counter stand-in: one clk advance covers both edges (1 or 2 counts).
  always @(posedge clk or negedge rst) begin
    if (!rst)         cnt_val <= '0;
    else if (stuck)   cnt_val <= WIDTH'(3);
    else if (cnt_clr) cnt_val <= '0;
    else if (cnt_en)  cnt_val <= cnt_val + WIDTH'(step);
  end

  // Reference: owner (-1 = none), cycles since grant, pending done flag.
  int m_own, m_age, m_tgt, m_last, m_lcnt;
  bit m_done, m_werr;

  task automatic model_reset();
    m_own = -1; m_age = 0; m_tgt = 0; m_last = 1; m_lcnt = 0;
    m_done = 1'b0; m_werr = 1'b0;
  endtask

  task automatic model_step(input logic r0, input logic r1,
                            input logic [WIDTH-1:0] t0, input logic [WIDTH-1:0] t1,
                            input logic [WIDTH-1:0] c);
    int w, t;
    bit rq;
    m_werr = 1'b0;
    if (m_done) begin
      m_done = 1'b0;
      m_own  = -1;
    end else if (m_own < 0) begin
      if (r0 || r1) begin
        if (r0 && r1) w = 1 - m_last;
        else          w = r1 ? 1 : 0;
        t      = (w == 1) ? int'(t1) : int'(t0);
        m_tgt  = (t > TGT_MAX) ? TGT_MAX : t;
        m_own  = w;
        m_last = w;
        m_age  = 0;
      end
    end else begin
      rq = (m_own == 1) ? r1 : r0;
      if (!rq) begin
        m_own = -1;
      end else if (m_age >= 1 && int'(c) >= m_tgt) begin
        m_done = 1'b1;
        m_lcnt = int'(c);
      end else if (WDOG_ON && m_age == WDOG_CYC) begin
        m_werr = 1'b1;
        m_own  = -1;
      end else begin
        m_age++;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all();
    bit act;
    act = (m_own >= 0) && !m_done;
    check("gnt0",     32'(bus.gnt0),     32'(m_own == 0));
    check("gnt1",     32'(bus.gnt1),     32'(m_own == 1));
    check("busy",     32'(bus.busy),     32'(m_own >= 0));
    check("done0",    32'(bus.done0),    32'(m_done && m_own == 0));
    check("done1",    32'(bus.done1),    32'(m_done && m_own == 1));
    check("cnt_clr",  32'(cnt_clr),      32'(act && m_age == 0));
    check("cnt_en",   32'(cnt_en),       32'(act && m_age >= 1 && int'(cnt_val) < m_tgt));
    check("last_cnt", 32'(bus.last_cnt), 32'(m_lcnt));
    check("wdog_err", 32'(bus.wdog_err), 32'(m_werr));
  endtask

  // One clock: capture pre-edge inputs, step model, compare after the edge.
  task automatic cycle();
    logic r0, r1;
    logic [WIDTH-1:0] t0, t1, c;
    r0 = bus.req0; r1 = bus.req1; t0 = bus.tgt0; t1 = bus.tgt1; c = cnt_val;
    @(posedge clk);
    #1;
    model_step(r0, r1, t0, t1, c);
    compare_all();
    step = rnd_step ? int'($urandom_range(1, 2)) : 2;
  endtask

  task automatic wait_done(input int k, input int budget, output int en_cyc);
    en_cyc = 0;
    for (int i = 0; i < budget; i++) begin
      cycle();
      if (cnt_en) en_cyc++;
      if ((k == 0) ? bus.done0 : bus.done1) return;
    end
    check("wait_done_timeout", 32'(0), 32'(1));
  endtask

  function automatic logic [WIDTH-1:0] pick_tgt();
    case ($urandom % 4)
      0:       return '0;
      1:       return '1;
      default: return WIDTH'($urandom);
    endcase
  endfunction

  initial begin
    int en_cyc, n, seq[3];
    bit seen;

    // Reset held across an edge with a request pending.
    rst = 1'b0;
    bus.req0 = 1'b1; bus.req1 = 1'b0; bus.tgt0 = WIDTH'(6); bus.tgt1 = '0;
    model_reset();
    @(posedge clk); #1;
    compare_all();
    #2 rst = 1'b1;

    // Single run to 6, stepping 2.
    cycle();
    check("rel_gnt0", 32'(bus.gnt0), 32'(1));
    check("rel_clr",  32'(cnt_clr),  32'(1));
    wait_done(0, 20, en_cyc);
    check("run_en_cycles", 32'(en_cyc),       32'(3));
    check("run_last_cnt",  32'(bus.last_cnt), 32'(6));
    bus.req0 = 1'b0;
    cycle();
    cycle();
    check("run_gnt0_off", 32'(bus.gnt0), 32'(0));

    // Asynchronous reset in the middle of a run.
    bus.req1 = 1'b1; bus.tgt1 = WIDTH'(10);
    repeat (4) cycle();
    #2 rst = 1'b0;
    #1;
    model_reset();
    compare_all();
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    bus.tgt0 = WIDTH'(2); bus.tgt1 = WIDTH'(2);
    #1 rst = 1'b1;

    // Both held: grants alternate 0, 1, 0.
    n = 0;
    for (int i = 0; i < 60 && n < 3; i++) begin
      cycle();
      if (cnt_clr) begin
        seq[n] = bus.gnt1 ? 1 : 0;
        n++;
      end
    end
    check("arb_count", 32'(n), 32'(3));
    check("arb_0", 32'(seq[0]), 32'(0));
    check("arb_1", 32'(seq[1]), 32'(1));
    check("arb_2", 32'(seq[2]), 32'(0));
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    repeat (4) cycle();

    // Terminal 15 is clamped to 14; one count of overshoot allowed.
    rnd_step = 1'b1;
    bus.req1 = 1'b1; bus.tgt1 = '1;
    wait_done(1, 40, en_cyc);
    check("clamp_last_cnt", 32'(bus.last_cnt == WIDTH'(14) || bus.last_cnt == WIDTH'(15)), 32'(1));
    bus.req1 = 1'b0;
    repeat (2) cycle();

    // Terminal 0: done three cycles after request, enable never raised.
    bus.req1 = 1'b1; bus.tgt1 = '0;
    seen = 1'b0;
    repeat (3) begin
      cycle();
      if (cnt_en) seen = 1'b1;
    end
    check("tgt0_done1", 32'(bus.done1), 32'(1));
    check("tgt0_no_en", 32'(seen),      32'(0));
    bus.req1 = 1'b0;
    repeat (2) cycle();

    // Abort two cycles into RUN with req1 pending.
    rnd_step = 1'b0;
    bus.req0 = 1'b1; bus.tgt0 = WIDTH'(12);
    bus.req1 = 1'b1; bus.tgt1 = WIDTH'(3);
    repeat (3) cycle();
    bus.req0 = 1'b0;
    cycle();
    check("abort_gnt0",   32'(bus.gnt0), 32'(0));
    check("abort_cnt_en", 32'(cnt_en),   32'(0));
    cycle();
    check("abort_gnt1",   32'(bus.gnt1), 32'(1));
    wait_done(1, 30, en_cyc);
    bus.req1 = 1'b0;
    repeat (2) cycle();

`ifdef CTRL_WDOG_EN
    // Counter stuck below target: watchdog must fire after WDOG_CYC RUN cycles.
    stuck = 1'b1;
    bus.req0 = 1'b1; bus.tgt0 = WIDTH'(8);
    n = 0; seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      n++;
      if (bus.done0) seen = 1'b1;
      if (bus.wdog_err) break;
    end
    check("wdog_cycles", 32'(n),        32'(WDOG_CYC + 2));
    check("wdog_pulse",  32'(bus.wdog_err), 32'(1));
    check("wdog_gnt0",   32'(bus.gnt0), 32'(0));
    check("wdog_nodone", 32'(seen),     32'(0));
    stuck = 1'b0;
    bus.req0 = 1'b0;
    repeat (2) cycle();
`endif

    // Random requesters: levels held until done or occasional abort.
    rnd_step = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if (!bus.req0) begin
        if ($urandom % 3 == 0) begin bus.req0 = 1'b1; bus.tgt0 = pick_tgt(); end
      end else if (bus.done0) begin
        if ($urandom % 2 == 0) bus.req0 = 1'b0;
      end else if ($urandom % 40 == 0) begin
        bus.req0 = 1'b0;
      end
      if (!bus.req1) begin
        if ($urandom % 3 == 0) begin bus.req1 = 1'b1; bus.tgt1 = pick_tgt(); end
      end else if (bus.done1) begin
        if ($urandom % 2 == 0) bus.req1 = 1'b0;
      end else if ($urandom % 40 == 0) begin
        bus.req1 = 1'b0;
      end
      cycle();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "simulation time limit");
  end

endmodule
`default_nettype wire
